// File: rtl/axis_frame_fifo_len.sv
// axis_frame_fifo_len: store-and-forward AXI4-Stream frame FIFO with commit/rollback, drop and status.
// Define AXIS_FRAME_FIFO_LEN_EN to build the per-frame length FIFO that drives m_axis_tlen.
module axis_frame_fifo_len #(
  parameter int DEPTH = 2048,
  parameter int DATA_WIDTH = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK = 1'b1,
  parameter bit DROP_BAD_FRAME = 1,
  parameter int MAX_FRAMES = 16,
  parameter int LEN_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_drop,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [USER_WIDTH-1:0]         s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [LEN_WIDTH-1:0]          m_axis_tlen,
  output logic [$clog2(DEPTH):0]        status_depth,
  output logic [$clog2(MAX_FRAMES):0]   status_frames,
  output logic                          status_overflow,
  output logic                          status_bad_frame,
  output logic                          status_good_frame
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = $clog2(MAX_FRAMES) + 1;
  localparam int MW = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] out_q;
  logic [PW-1:0] wr_cur, wr_commit, rd_ptr;
  logic [FW-1:0] frames;
  logic [KEEP_WIDTH-1:0] keep_in;
  logic drop_frame, drop_ovf, in_frame;
  logic s_fire, m_fire, bad, write, commit, pop, load;
  assign keep_in = KEEP_ENABLE ? s_axis_tkeep : '1;
  assign s_fire = s_axis_tvalid && s_axis_tready;
  assign m_fire = m_axis_tvalid && m_axis_tready;
  assign bad = DROP_BAD_FRAME && ((s_axis_tuser & USER_BAD_FRAME_MASK) == (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK));
  assign write = s_fire && !drop_frame && !s_drop;
  assign commit = write && s_axis_tlast && !bad;
  assign pop = m_fire && m_axis_tlast;
  assign load = (!m_axis_tvalid || m_fire) && rd_ptr != wr_commit;
  assign s_axis_tready = drop_frame || ((wr_cur - rd_ptr) != PW'(DEPTH) && frames < FW'(MAX_FRAMES));
  assign status_depth = wr_commit - rd_ptr + PW'(m_axis_tvalid);
  assign status_frames = frames;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = out_q;
  always_ff @(posedge clk)
    if (write) mem[wr_cur[AW-1:0]] <= {s_axis_tdata, keep_in, s_axis_tlast, s_axis_tuser};
  // While drop_frame is set, beats are swallowed until the frame's tlast closes it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_cur <= '0;
      wr_commit <= '0;
      drop_frame <= 1'b0;
      drop_ovf <= 1'b0;
      in_frame <= 1'b0;
      status_overflow <= 1'b0;
      status_bad_frame <= 1'b0;
      status_good_frame <= 1'b0;
    end else begin
      status_overflow <= 1'b0;
      status_bad_frame <= 1'b0;
      status_good_frame <= 1'b0;
      if (s_fire) in_frame <= !s_axis_tlast;
      if (drop_frame) begin
        if (s_fire && s_axis_tlast) begin
          drop_frame <= 1'b0;
          drop_ovf <= 1'b0;
          status_overflow <= drop_ovf;
        end
      end else if (s_drop) begin
        wr_cur <= wr_commit;
        drop_frame <= s_fire ? !s_axis_tlast : in_frame;
      end else if (s_fire) begin
        if (s_axis_tlast && bad) begin
          wr_cur <= wr_commit;
          status_bad_frame <= 1'b1;
        end else if (s_axis_tlast) begin
          wr_cur <= wr_cur + PW'(1);
          wr_commit <= wr_cur + PW'(1);
          status_good_frame <= 1'b1;
        end else if (wr_cur + PW'(1) - wr_commit == PW'(DEPTH)) begin
          wr_cur <= wr_commit;
          drop_frame <= 1'b1;
          drop_ovf <= 1'b1;
        end else
          wr_cur <= wr_cur + PW'(1);
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frames <= '0;
    else frames <= frames + FW'(commit) - FW'(pop);
  // Single output stage refills on the cycle it drains, so committed beats stream back-to-back.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      m_axis_tvalid <= 1'b0;
      out_q <= '0;
    end else if (load) begin
      rd_ptr <= rd_ptr + PW'(1);
      m_axis_tvalid <= 1'b1;
      out_q <= mem[rd_ptr[AW-1:0]];
    end else if (m_fire)
      m_axis_tvalid <= 1'b0;
`ifdef AXIS_FRAME_FIFO_LEN_EN
  localparam int LAW = $clog2(MAX_FRAMES);
  localparam int BW = $clog2(KEEP_WIDTH + 1);
  localparam int LW1 = LEN_WIDTH + 1;
  logic [LEN_WIDTH-1:0] len_mem [MAX_FRAMES];
  logic [LEN_WIDTH-1:0] len_acc, len_nxt;
  logic [LW1-1:0] len_sum;
  logic [LAW-1:0] len_wr, len_rd;
  logic [BW-1:0] beat_bytes;
  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) beat_bytes = beat_bytes + BW'(keep_in[i]);
    len_sum = {1'b0, len_acc} + LW1'(beat_bytes);
    len_nxt = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];
  end
  always_ff @(posedge clk)
    if (commit) len_mem[len_wr] <= len_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len_acc <= '0;
      len_wr <= '0;
      len_rd <= '0;
    end else begin
      if (write) len_acc <= s_axis_tlast ? '0 : len_nxt;
      else if (s_drop || drop_frame) len_acc <= '0;
      if (commit) len_wr <= len_wr + LAW'(1);
      if (pop) len_rd <= len_rd + LAW'(1);
    end
  assign m_axis_tlen = m_axis_tvalid ? len_mem[len_rd] : '0;
`else
  assign m_axis_tlen = '0;
`endif
endmodule
